gray_seq_ctrl: RTL and testbench

Sequencer that owns and drives a WIDTH-bit Gray-code counter.
- Runs the counter for a programmed number of steps, up or down, in one-shot or continuous mode, under a start/stop/done handshake.
- Sits between a control master (FSM or register block) and the Gray counter datapath. It replaces free-running Gray counters wherever the counter must be gated, bounded or reversed.

---
 rtl/gray_pkg.sv | 15 +
 rtl/gray_core.sv | 50 +++++
 rtl/gray_seq_ctrl.sv | 104 ++++++++++
 tb/tb_gray_seq_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared constants for the Gray-code sequencer: FSM state encoding and the
// meaning of the mode/dir control bits.
package gray_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CONT    = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/gray_core.sv
// Gray counter datapath: binary register that advances up or down on adv,
// with a registered Gray encode and a registered one-cycle wrap pulse.
module gray_core
  import gray_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             dir,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] BIN_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] BIN_MAX = '1;

  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] bin_nxt;
  logic             wrap_nxt;

  always_comb begin
    bin_nxt  = bin;
    wrap_nxt = 1'b0;
    if (adv) begin
      if (dir == DIR_DOWN) begin
        bin_nxt  = bin - BIN_ONE;
        wrap_nxt = (bin == '0);
      end else begin
        bin_nxt  = bin + BIN_ONE;
        wrap_nxt = (bin == BIN_MAX);
      end
    end
  end

  // Gray is encoded from the next binary value so it lands in the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bin  <= '0;
      gray <= '0;
      wrap <= 1'b0;
    end else begin
      bin  <= bin_nxt;
      gray <= bin_nxt ^ (bin_nxt >> 1);
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: rtl/gray_seq_ctrl.sv
// Run controller for a Gray counter: bounded one-shot or continuous runs,
// up or down, with start/stop/done handshake and a remaining-steps counter.
module gray_seq_ctrl
  import gray_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             dir,
  input  logic [CNT_W-1:0] steps,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic [WIDTH-1:0] gray_out,
  output logic [1:0]       state_dbg
);

  // Handshake: start is sampled only in IDLE, stop only in RUN; done and
  // wrap are single-cycle pulses; busy mirrors the RUN state.
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] remaining_nxt;
  logic [CNT_W-1:0] steps_q;
  logic             mode_q;
  logic             dir_q;
  logic             adv;
  logic             last;
  logic             done_nxt;
  logic             accept;

  assign accept    = (state == IDLE) && start && (steps != '0);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      steps_q   <= '0;
      mode_q    <= 1'b0;
      dir_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      busy      <= (state_nxt == RUN);
      done      <= done_nxt;
      if (accept) begin
        steps_q <= steps;
        mode_q  <= mode;
        dir_q   <= dir;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (steps != '0) ? RUN : DONE;
      end
      RUN: begin
        if (stop) state_nxt = IDLE;
        else if ((remaining <= CNT_ONE) && (mode_q == MODE_ONESHOT)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A stop in RUN suppresses the advance, so it also wins over a final step.
  always_comb begin
    adv           = (state == RUN) && !stop;
    last          = adv && (remaining <= CNT_ONE);
    done_nxt      = (state_nxt == DONE) || (last && (mode_q == MODE_CONT));
    remaining_nxt = remaining;
    if (accept) begin
      remaining_nxt = steps;
    end else if (adv) begin
      if (last) remaining_nxt = (mode_q == MODE_CONT) ? steps_q : '0;
      else      remaining_nxt = remaining - CNT_ONE;
    end
  end

  gray_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .adv (adv),
    .dir (dir_q),
    .gray(gray_out),
    .wrap(wrap)
  );

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Directed bench for gray_seq_ctrl (WIDTH=2) with hand-computed expectations.
module tb_gray_seq_ctrl;
  import gray_pkg::*;

  localparam int WIDTH = 2;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             stop;
  logic             mode;
  logic             dir;
  logic [CNT_W-1:0] steps;
  logic             busy;
  logic             done;
  logic             wrap;
  logic [WIDTH-1:0] gray_out;
  logic [1:0]       state_dbg;

  int checks = 0;
  int errors = 0;

  gray_seq_ctrl #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .dir      (dir),
    .steps    (steps),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap),
    .gray_out (gray_out),
    .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full output snapshot: gray, busy, done, wrap, state.
  task automatic chk_all(input string tag, input logic [1:0] g, input logic b,
                         input logic d, input logic w, input logic [1:0] s);
    chk({tag, ".gray"},  32'(gray_out),  32'(g));
    chk({tag, ".busy"},  32'(busy),      32'(b));
    chk({tag, ".done"},  32'(done),      32'(d));
    chk({tag, ".wrap"},  32'(wrap),      32'(w));
    chk({tag, ".state"}, 32'(state_dbg), 32'(s));
  endtask

  logic [1:0] exp_up [4];

  initial begin
    exp_up = '{2'b01, 2'b11, 2'b10, 2'b00};
    rst = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; dir = 1'b0; steps = '0;

    // Reset held for two edges, then released.
    tick(); tick();
    chk_all("rst_hold", 2'b00, 1'b0, 1'b0, 1'b0, IDLE);
    rst = 1'b1;
    tick();
    chk_all("rst_rel", 2'b00, 1'b0, 1'b0, 1'b0, IDLE);

    // One-shot up, 4 steps: 01,11,10,00 then wrap + done together.
    start = 1'b1; mode = MODE_ONESHOT; dir = DIR_UP; steps = 8'd4;
    tick();
    start = 1'b0;
    chk_all("up_start", 2'b00, 1'b1, 1'b0, 1'b0, RUN);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("up_adv%0d", i), exp_up[i], 1'b1, 1'b0, 1'b0, RUN);
    end
    tick();
    chk_all("up_last", exp_up[3], 1'b0, 1'b1, 1'b1, DONE);
    tick();
    chk_all("up_idle", 2'b00, 1'b0, 1'b0, 1'b0, IDLE);

    // One-shot down, 3 steps from 00: 10 (wrap), 11, 01 (done).
    start = 1'b1; dir = DIR_DOWN; steps = 8'd3;
    tick();
    start = 1'b0;
    chk_all("dn_start", 2'b00, 1'b1, 1'b0, 1'b0, RUN);
    tick();
    chk_all("dn_adv0", 2'b10, 1'b1, 1'b0, 1'b1, RUN);
    tick();
    chk_all("dn_adv1", 2'b11, 1'b1, 1'b0, 1'b0, RUN);
    tick();
    chk_all("dn_last", 2'b01, 1'b0, 1'b1, 1'b0, DONE);
    tick();
    chk_all("dn_idle", 2'b01, 1'b0, 1'b0, 1'b0, IDLE);

    // Continuous up, 2 steps from bin 1: 11, 10(done), 00(wrap), 01(done).
    start = 1'b1; mode = MODE_CONT; dir = DIR_UP; steps = 8'd2;
    tick();
    start = 1'b0;
    chk_all("ct_start", 2'b01, 1'b1, 1'b0, 1'b0, RUN);
    tick();
    chk_all("ct_adv0", 2'b11, 1'b1, 1'b0, 1'b0, RUN);
    tick();
    chk_all("ct_adv1", 2'b10, 1'b1, 1'b1, 1'b0, RUN);
    // A new start while busy (down, zero steps) must be ignored.
    start = 1'b1; dir = DIR_DOWN; steps = 8'd0; mode = MODE_ONESHOT;
    tick();
    chk_all("ct_adv2", 2'b00, 1'b1, 1'b0, 1'b1, RUN);
    start = 1'b0;
    tick();
    chk_all("ct_adv3", 2'b01, 1'b1, 1'b1, 1'b0, RUN);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_all("ct_stop", 2'b01, 1'b0, 1'b0, 1'b0, IDLE);
    tick();
    chk_all("ct_after", 2'b01, 1'b0, 1'b0, 1'b0, IDLE);

    // Empty run: done pulse, gray unchanged, never busy.
    start = 1'b1; steps = 8'd0; mode = MODE_ONESHOT; dir = DIR_UP;
    tick();
    start = 1'b0;
    chk_all("zero_done", 2'b01, 1'b0, 1'b1, 1'b0, DONE);
    tick();
    chk_all("zero_idle", 2'b01, 1'b0, 1'b0, 1'b0, IDLE);

    // Stop coincident with the final one-shot step wins.
    start = 1'b1; steps = 8'd2;
    tick();
    start = 1'b0;
    tick();
    chk_all("sf_adv0", 2'b11, 1'b1, 1'b0, 1'b0, RUN);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_all("sf_stop", 2'b11, 1'b0, 1'b0, 1'b0, IDLE);
    tick();
    chk_all("sf_after", 2'b11, 1'b0, 1'b0, 1'b0, IDLE);

    // Single-step run: bin 2 -> 3 (gray 10), done on the same cycle as the advance.
    start = 1'b1; steps = 8'd1;
    tick();
    start = 1'b0;
    tick();
    chk_all("one_last", 2'b10, 1'b0, 1'b1, 1'b0, DONE);
    tick();
    chk_all("one_idle", 2'b10, 1'b0, 1'b0, 1'b0, IDLE);

    // Reset mid-run after two advances: 00 (wrap), 01, then cleared.
    start = 1'b1; steps = 8'd5;
    tick();
    start = 1'b0;
    tick();
    chk_all("rm_adv0", 2'b00, 1'b1, 1'b0, 1'b1, RUN);
    tick();
    chk_all("rm_adv1", 2'b01, 1'b1, 1'b0, 1'b0, RUN);
    rst = 1'b0;
    tick();
    chk_all("rm_reset", 2'b00, 1'b0, 1'b0, 1'b0, IDLE);
    rst = 1'b1;
    tick();
    chk_all("rm_after", 2'b00, 1'b0, 1'b0, 1'b0, IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
